vga_pll_sequencer: RTL and testbench

Reset/lock sequencer for the VGA pixel-clock PLL (50 MHz refclk in, ~33.29 MHz pixel clock out). Runs in the refclk domain. Pulses the PLL reset, waits for a stable lock, then releases the video-pipeline reset. On lock loss or a software relock request it re-sequences the PLL, with a bounded retry count and a sticky error flag.

---
 rtl/vga_pll_sequencer.sv | 137 +++++++++++++
 tb/tb_vga_pll_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pll_sequencer.sv
// Reset/lock sequencer for the VGA pixel-clock PLL, running entirely in the refclk domain.
// Pulses the PLL reset, qualifies lock, releases the video reset, and re-sequences on loss or request.
module vga_pll_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 17
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       video_rst_n,
    output logic       pll_ready,
    output logic       pll_error,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       MAX_R       = 2'(MAX_RETRIES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         retry_q, retry_d;
    logic               error_q, error_d;
    logic [1:0]         sync_q;
    logic               pll_rst_q, video_rst_n_q, ready_q;
    logic               lock_s;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        error_d = error_q;
        if (relock_req) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            if (state_q == ERROR) begin
                error_d = 1'b0;
                retry_d = '0;
            end
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == MAX_R) begin
                            state_d = ERROR;
                            error_d = 1'b1;
                        end else begin
                            state_d = PLL_RST;
                            retry_d = (retry_q == 2'b11) ? retry_q : retry_q + 1'b1;
                        end
                    end
                end
                // Lock loss takes precedence over the terminal count and is not a failed attempt.
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!lock_s) state_d = PLL_RST;
                end
                ERROR: begin
                    cnt_d   = '0;
                    error_d = 1'b1;
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PLL_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            error_q       <= 1'b0;
            sync_q        <= '0;
            pll_rst_q     <= 1'b1;
            video_rst_n_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            error_q       <= error_d;
            sync_q        <= {sync_q[0], pll_locked};
            pll_rst_q     <= (state_d == PLL_RST) || (state_d == ERROR);
            video_rst_n_q <= (state_d == RUN);
            ready_q       <= (state_d == RUN);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign video_rst_n = video_rst_n_q;
    assign pll_ready   = ready_q;
    assign pll_error   = error_q;
    assign retry_cnt   = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_vga_pll_sequencer.sv
// Directed bench for vga_pll_sequencer with short timing parameters.
// Each scenario task drives stimulus and checks hand-computed cycle counts inline.
module tb_vga_pll_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       video_rst_n;
    logic       pll_ready;
    logic       pll_error;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    vga_pll_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3),
        .CNT_W        (17)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .video_rst_n(video_rst_n),
        .pll_ready  (pll_ready),
        .pll_error  (pll_error),
        .retry_cnt  (retry_cnt),
        .state_dbg  (state_dbg)
    );

    always #5 refclk = ~refclk;

    // Counts rising edges (sampling 1 time unit after each) until pll_rst reaches lvl, bounded.
    task automatic edges_until_pll_rst(input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge refclk); #1;
            n++;
        end while (pll_rst !== lvl && n < 200);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
        #12;
        checks++;
        if ({pll_rst, video_rst_n, pll_ready, pll_error, retry_cnt, state_dbg} !== 9'b1_0_0_0_00_000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {pll_rst, video_rst_n, pll_ready, pll_error, retry_cnt, state_dbg}, 9'b100000000);
        end
    endtask

    task automatic test_bringup;
        int n;
        @(negedge refclk); rst_n = 1'b1;
        edges_until_pll_rst(1'b0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL bringup_pll_rst_width: got %0d expected 4", n); end
        @(posedge refclk); #1;
        pll_locked = 1'b1;
        @(posedge refclk); #1;
        n = 0;
        while (video_rst_n !== 1'b1 && n < 100) begin
            @(posedge refclk); #1;
            n++;
        end
        checks++;
        if (n !== 10) begin errors++; $display("FAIL bringup_release_latency: got %0d expected 10", n); end
        checks++;
        if (pll_ready !== 1'b1) begin errors++; $display("FAIL bringup_ready: got %b expected 1", pll_ready); end
        checks++;
        if (retry_cnt !== 2'd0) begin errors++; $display("FAIL bringup_retry: got %0d expected 0", retry_cnt); end
        checks++;
        if (state_dbg !== 3'd3) begin errors++; $display("FAIL bringup_state: got %0d expected 3", state_dbg); end
    endtask

    task automatic test_lock_loss;
        int n;
        @(posedge refclk); #1;
        pll_locked = 1'b0;
        @(posedge refclk); #1;
        pll_locked = 1'b1;
        n = 1;
        while (video_rst_n !== 1'b0 && n < 20) begin
            @(posedge refclk); #1;
            n++;
        end
        checks++;
        if (n > 3) begin errors++; $display("FAIL lockloss_video_rst_latency: got %0d expected <=3", n); end
        checks++;
        if (pll_ready !== 1'b0) begin errors++; $display("FAIL lockloss_ready: got %b expected 0", pll_ready); end
        checks++;
        if (pll_rst !== 1'b1) begin errors++; $display("FAIL lockloss_pll_rst: got %b expected 1", pll_rst); end
        edges_until_pll_rst(1'b0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL lockloss_pll_rst_width: got %0d expected 4", n); end
        n = 0;
        while (pll_ready !== 1'b1 && n < 50) begin
            @(posedge refclk); #1;
            n++;
        end
        checks++;
        if (pll_ready !== 1'b1) begin errors++; $display("FAIL lockloss_rerun: got %b expected 1", pll_ready); end
        checks++;
        if (retry_cnt !== 2'd0) begin errors++; $display("FAIL lockloss_retry: got %0d expected 0", retry_cnt); end
    endtask

    task automatic test_stable_glitch;
        int n;
        @(negedge refclk); relock_req = 1'b1;
        @(negedge refclk); relock_req = 1'b0;
        checks++;
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL relock_from_run_state: got %0d expected 0", state_dbg); end
        n = 0;
        while (state_dbg !== 3'd2 && n < 50) begin
            @(negedge refclk);
            n++;
        end
        repeat (3) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk); pll_locked = 1'b1;
        @(negedge refclk);
        @(negedge refclk);
        checks++;
        if (state_dbg !== 3'd1) begin errors++; $display("FAIL glitch_to_wait_lock: got %0d expected 1", state_dbg); end
        checks++;
        if (retry_cnt !== 2'd0) begin errors++; $display("FAIL glitch_retry: got %0d expected 0", retry_cnt); end
        @(negedge refclk);
        checks++;
        if (state_dbg !== 3'd2) begin errors++; $display("FAIL glitch_restable: got %0d expected 2", state_dbg); end
        n = 0;
        while (pll_ready !== 1'b1 && n < 50) begin
            @(negedge refclk);
            n++;
        end
        checks++;
        if (n !== 8) begin errors++; $display("FAIL glitch_stable_restart: got %0d expected 8", n); end
    endtask

    task automatic test_retries;
        int n;
        rst_n = 1'b0; pll_locked = 1'b0;
        #17;
        @(negedge refclk); rst_n = 1'b1;
        edges_until_pll_rst(1'b0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL retry_first_pulse: got %0d expected 4", n); end
        for (int i = 1; i <= 3; i++) begin
            edges_until_pll_rst(1'b1, n);
            checks++;
            if (n !== 20) begin errors++; $display("FAIL retry_timeout_%0d: got %0d expected 20", i, n); end
            checks++;
            if (retry_cnt !== 2'(i)) begin errors++; $display("FAIL retry_count_%0d: got %0d expected %0d", i, retry_cnt, i); end
            edges_until_pll_rst(1'b0, n);
            checks++;
            if (n !== 4) begin errors++; $display("FAIL retry_pulse_%0d: got %0d expected 4", i, n); end
        end
        edges_until_pll_rst(1'b1, n);
        checks++;
        if (n !== 20) begin errors++; $display("FAIL error_timeout: got %0d expected 20", n); end
        checks++;
        if (pll_error !== 1'b1) begin errors++; $display("FAIL error_flag: got %b expected 1", pll_error); end
        checks++;
        if (state_dbg !== 3'd4) begin errors++; $display("FAIL error_state: got %0d expected 4", state_dbg); end
        checks++;
        if (retry_cnt !== 2'd3) begin errors++; $display("FAIL error_retry: got %0d expected 3", retry_cnt); end
        repeat (30) @(posedge refclk);
        #1;
        checks++;
        if ({pll_rst, pll_error, video_rst_n, state_dbg} !== 6'b110_100) begin
            errors++;
            $display("FAIL error_held: got %b expected 110100", {pll_rst, pll_error, video_rst_n, state_dbg});
        end
    endtask

    task automatic test_error_relock;
        int n;
        relock_req = 1'b1; pll_locked = 1'b1;
        @(posedge refclk); #1;
        relock_req = 1'b0;
        checks++;
        if (pll_error !== 1'b0) begin errors++; $display("FAIL relock_error_clear: got %b expected 0", pll_error); end
        checks++;
        if (retry_cnt !== 2'd0) begin errors++; $display("FAIL relock_retry_clear: got %0d expected 0", retry_cnt); end
        checks++;
        if (state_dbg !== 3'd0 || pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL relock_state: got state=%0d pll_rst=%b expected state=0 pll_rst=1", state_dbg, pll_rst);
        end
        n = 0;
        while (pll_ready !== 1'b1 && n < 100) begin
            @(posedge refclk); #1;
            n++;
        end
        checks++;
        if (n !== 13) begin errors++; $display("FAIL relock_run_latency: got %0d expected 13", n); end
        checks++;
        if (video_rst_n !== 1'b1) begin errors++; $display("FAIL relock_video: got %b expected 1", video_rst_n); end
    endtask

    task automatic test_async_reset;
        int n;
        @(negedge refclk); relock_req = 1'b1;
        @(negedge refclk); relock_req = 1'b0;
        n = 0;
        while (state_dbg !== 3'd2 && n < 50) begin
            @(negedge refclk);
            n++;
        end
        @(negedge refclk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pll_rst, video_rst_n, pll_ready, pll_error, retry_cnt, state_dbg} !== 9'b1_0_0_0_00_000) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b expected %b",
                     {pll_rst, video_rst_n, pll_ready, pll_error, retry_cnt, state_dbg}, 9'b100000000);
        end
    endtask

    initial begin
        test_reset;
        test_bringup;
        test_lock_loss;
        test_stable_glitch;
        test_retries;
        test_error_relock;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
